// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the RV32M multiply/divide sequencer
// Contents: default operand width, func3 opcodes, FSM state encoding and
// small operand-signedness helpers used by the sequencer.
package muldiv_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    // MUL stays unsigned: the low product half does not depend on signedness.
    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == MULH) || (f3 == MULHSU) || (f3 == DIV) || (f3 == REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM only.
    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == MULH) || (f3 == DIV) || (f3 == REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - execute-stage to mul/div sequencer handshake bundle
// master: execute stage (drives start/func3/data1/data2/flush, sees stall/busy/valid/result)
// slave : muldiv_sequencer
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, func3, data1, data2, flush,
        input  stall, busy, valid, result
    );

    modport slave (
        input  start, func3, data1, data2, flush,
        output stall, busy, valid, result
    );
endinterface

// File: rtl/muldiv_iter_step.sv
// rtl/muldiv_iter_step.sv - one shift-add / restoring-divide iteration on the accumulator
// Ports: mode_div (0 multiply, 1 divide), acc_in/acc_out (2*XLEN accumulator),
// operand (multiplicand for multiply, divisor for divide). Purely combinational.
module muldiv_iter_step #(
    parameter int XLEN = 32
) (
    input  logic              mode_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_hi;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    always_comb begin
        // Multiply: conditional add into the upper half, carry shifted back in.
        mul_sum  = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
        // Divide: the shifted partial remainder needs XLEN+1 bits when the
        // divisor has its MSB set, so the bit shifted out is kept for the compare.
        div_hi   = acc_in[2*XLEN-1:XLEN-1];
        div_ge   = div_hi >= {1'b0, operand};
        div_diff = div_hi[XLEN-1:0] - operand;
        if (mode_div) begin
            acc_out = {(div_ge ? div_diff : div_hi[XLEN-1:0]), acc_in[XLEN-2:0], div_ge};
        end else begin
            acc_out = {mul_sum, acc_in[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide controller
// Ports: CLK (rising edge), RESET (async, active low), bus (slave side of
// muldiv_sequencer_if: start/func3/data1/data2/flush in; stall/busy/valid/result out).
// Sequence: IDLE -> CALC (XLEN iterations) -> FIX (sign/half select) -> DONE (valid pulse).
// Divide-by-zero and signed overflow skip straight from IDLE to DONE.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic           CLK,
    input  logic           RESET,
    muldiv_sequencer_if.slave bus
);
    localparam int ITER = XLEN;
    localparam int CW   = $clog2(ITER);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state, state_nx;
    logic [CW-1:0]       count;
    logic [2*XLEN-1:0]   acc, acc_step;
    logic [XLEN-1:0]     opnd;
    logic [XLEN-1:0]     result_q;
    logic [2:0]          op_q;
    logic                neg_q;

    logic                accept, fast_hit, sign_a, sign_b, neg_in;
    logic                stall_c, busy_c, valid_c;
    logic [XLEN-1:0]     mag_a, mag_b, fast_res, fix_res, quot, rem;
    logic [2*XLEN-1:0]   prod;

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .mode_div (op_q[2]),
        .acc_in   (acc),
        .operand  (opnd),
        .acc_out  (acc_step)
    );

    // Operand magnitudes, result sign and the IDLE fast-path result.
    always_comb begin
        sign_a   = op_a_signed(bus.func3) & bus.data1[XLEN-1];
        sign_b   = op_b_signed(bus.func3) & bus.data2[XLEN-1];
        mag_a    = sign_a ? -bus.data1 : bus.data1;
        mag_b    = sign_b ? -bus.data2 : bus.data2;
        // Remainder follows the dividend; product and quotient use the XOR.
        neg_in   = (bus.func3[2] & bus.func3[1]) ? sign_a : (sign_a ^ sign_b);
        fast_hit = 1'b0;
        fast_res = '0;
        if (bus.func3[2] && bus.data2 == '0) begin
            fast_hit = 1'b1;
            fast_res = bus.func3[1] ? bus.data1 : '1;
        end else if ((bus.func3 == DIV || bus.func3 == REM) &&
                     bus.data1 == MIN_NEG && bus.data2 == '1) begin
            fast_hit = 1'b1;
            fast_res = bus.func3[1] ? '0 : MIN_NEG;
        end
    end

    // Sign fix-up and result half/quotient/remainder selection in FIX.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            MUL:                 fix_res = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_res = prod[2*XLEN-1:XLEN];
            DIV, DIVU:           fix_res = quot;
            default:             fix_res = rem;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        stall_c  = 1'b0;
        busy_c   = 1'b0;
        valid_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept   = 1'b1;
                    stall_c  = 1'b1;
                    state_nx = fast_hit ? DONE : CALC;
                end
            end
            CALC: begin
                stall_c = 1'b1;
                busy_c  = 1'b1;
                if (bus.flush) begin
                    state_nx = IDLE;
                end else if (count == '0) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                stall_c  = 1'b1;
                busy_c   = 1'b1;
                state_nx = bus.flush ? IDLE : DONE;
            end
            DONE: begin
                busy_c   = 1'b1;
                valid_c  = !bus.flush;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc      <= '0;
            opnd     <= '0;
            count    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= bus.func3;
                        neg_q <= neg_in;
                        count <= CW'(ITER - 1);
                        if (fast_hit) begin
                            result_q <= fast_res;
                        end else if (bus.func3[2]) begin
                            acc  <= {{XLEN{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{XLEN{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        result_q <= fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall  = stall_c;
    assign bus.busy   = busy_c;
    assign bus.valid  = valid_c;
    assign bus.result = result_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the RV32M multiply/divide operations issued by the execute stage.
- Replaces the single-cycle combinational mul path with an iterative shift-add multiplier and a restoring divider sharing one accumulator.
- Sequences the operation and stalls the pipeline while busy.
- Presents a one-cycle-valid result that the execute stage result mux selects.

Parameters:
- XLEN, 32: operand and result width.
- ITER, XLEN: iteration count; derived, not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- start  in  1  issue request; sampled only in IDLE.
- func3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- data1  in  XLEN  rs1 operand (multiplicand / dividend).
- data2  in  XLEN  rs2 operand (multiplier / divisor).
- flush  in  1  kill the in-flight operation (branch/jump taken).
- stall  out  1  freeze upstream pipeline registers.
- busy  out  1  operation in progress.
- valid  out  1  result valid; one-cycle pulse.
- result  out  XLEN  selected product half, quotient or remainder.

Behaviour:
- Reset (RESET=0, async):
  - state=IDLE.
  - busy=0, valid=0, result=0.
  - Internal accumulator, operand and count registers all 0.
- States: IDLE, CALC, FIX, DONE (encoded 2'b00..2'b11).
- IDLE:
  - If start=1 and flush=0, latch func3 and the operand magnitudes. Signed ops take the absolute value of signed operands. MULHSU treats only data1 as signed.
  - Latch the result sign.
  - Load count=ITER-1 and go to CALC.
  - Fast path, from IDLE straight to DONE with the result computed in that cycle:
    - DIV/DIVU with data2=0: quotient=all ones.
    - REM/REMU with data2=0: remainder=data1.
    - DIV with data1=0x80000000 and data2=0xFFFFFFFF: quotient=0x80000000.
    - REM with the same operands: remainder=0.
- CALC:
  - One iteration per cycle on a 2*XLEN accumulator.
  - Multiply: if the LSB of the multiplier is 1, add the multiplicand to the upper half, then shift right 1 (carry kept).
  - Divide: shift left 1, trial-subtract the divisor from the upper half. If non-negative, keep the difference and set quotient bit 1; else restore.
  - count decrements each cycle; at count=0 go to FIX.
- FIX:
  - Two's-complement negate when the latched sign=1.
  - Product sign = sign(a) XOR sign(b) over 64 bits.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign of the dividend.
  - Select result: MUL low 32; MULH/MULHSU/MULHU high 32; DIV/DIVU quotient; REM/REMU remainder.
  - Go to DONE.
- DONE: valid=1 and result registered; go to IDLE next cycle.
- Latency, start accepted at cycle T:
  - Normal path: busy=1 for T+1..T+34, valid=1 at T+34 only. That is 32 CALC cycles, 1 FIX, 1 DONE.
  - Fast path: valid=1 at T+1.
- Stall:
  - Combinational: stall = (state==IDLE & start & ~flush) | state==CALC | state==FIX.
  - stall=0 in DONE so the pipeline advances and captures result.
- busy=1 in CALC, FIX and DONE.
- result holds its last value when valid=0; consumers qualify it with valid.
- start when state≠IDLE: ignored; no queueing.
- flush:
  - In any state, next state is IDLE and valid is never asserted for the killed op.
  - flush with start in IDLE: not accepted.
  - flush has priority over the DONE→IDLE transition; valid is suppressed that cycle.
- Back-to-back: start may be high in the IDLE cycle immediately after DONE; it is accepted normally.
- Reset mid-operation aborts immediately; no valid.

Decomposition:
- Package muldiv_pkg:
  - func3 localparams: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - State encodings IDLE/CALC/FIX/DONE.
  - XLEN default.
- One natural sub-module, muldiv_iter_step: combinational single-iteration add-shift / subtract-restore on the accumulator, selected by a mode bit.
- FSM, counter and sign fix-up stay in muldiv_sequencer.

Test Plan:
- MUL 7×6, start at T → stall=1 T..T+33, valid=1 only at T+34, result=42.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHU same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → −3 (0xFFFFFFFD). REM −7/2 → −1. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV x/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000. REM same → 0. All with valid at T+1.
- flush asserted at T+10 of a DIV → IDLE at T+11, valid never pulses, stall=0. New start at T+11 completes normally at T+45.
- RESET low mid-CALC → busy/valid/result=0 immediately. start during busy → ignored, only the original op's result appears.
